// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer slice.
package alu_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  // Instruction word field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_LDI  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_INC  = 4'h3;
  localparam opcode_t OP_DEC  = 4'h4;
  localparam opcode_t OP_OR   = 4'h5;
  localparam opcode_t OP_AND  = 4'h6;
  localparam opcode_t OP_XOR  = 4'h7;
  localparam opcode_t OP_SHR  = 4'h8;
  localparam opcode_t OP_SHL  = 4'h9;
  localparam opcode_t OP_ONES = 4'hA;
  localparam opcode_t OP_TWOS = 4'hB;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  // 0xC-0xF are not decoded
  function automatic logic is_legal(opcode_t op);
    return op <= OP_TWOS;
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// Command / response handshake bundle between a command source and the sequencer.
interface alu_sequencer_if;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [15:0]               cmd_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [alu_pkg::DATA_W-1:0] rsp_data;
  logic                      rsp_zero;
  logic                      rsp_carry;
  logic                      rsp_err;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU. LDI and undecoded opcodes produce X; the
// sequencer never samples the outputs for those.
module alu
  import alu_pkg::*;
(
  input  opcode_t           i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);
  // Carry is carry-out for add/inc, borrow for sub/dec/negate, shifted-out
  // MSB for SHL; logical ops and SHR clear it.
  always_comb begin
    o_result = 'x;
    o_carry  = 1'bx;
    case (i_opcode)
      OP_ADD:  {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
      OP_INC:  {o_carry, o_result} = {1'b0, i_a} + 9'd1;
      OP_DEC:  {o_carry, o_result} = {1'b0, i_a} - 9'd1;
      OP_OR:   begin o_result = i_a | i_b; o_carry = 1'b0; end
      OP_AND:  begin o_result = i_a & i_b; o_carry = 1'b0; end
      OP_XOR:  begin o_result = i_a ^ i_b; o_carry = 1'b0; end
      OP_SHR:  begin o_result = i_a >> 1;  o_carry = 1'b0; end
      OP_SHL:  {o_carry, o_result} = {i_a, 1'b0};
      OP_ONES: begin o_result = ~i_a;      o_carry = 1'b0; end
      OP_TWOS: {o_carry, o_result} = 9'd0 - {1'b0, i_a};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_ra,
  input  logic [1:0]        i_rb,
  input  logic              i_we,
  input  logic [1:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rda,
  output logic [DATA_W-1:0] o_rdb
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  // Write port; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (reset)     r_regs       <= '0;
    else if (i_we) r_regs[i_wa] <= i_wd;
  end

  assign o_rda = r_regs[i_ra];
  assign o_rdb = r_regs[i_rb];
endmodule

// File: rtl/alu_sequencer.sv
// Sequencer: accept instruction, run one EXEC cycle on the ALU, write back,
// hold the response until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    cmd_if,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b
);
  state_t            r_state;
  opcode_t           r_op;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_imm, r_a, r_b;
  logic              r_zero, r_carry;
  logic              r_cmd_ready, r_rsp_valid, r_rsp_zero, r_rsp_carry, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data;

  logic [DATA_W-1:0] w_rda, w_rdb, w_alu_result, w_wd;
  logic              w_alu_carry, w_accept, w_legal, w_ldi, w_we;

  assign w_accept = cmd_if.cmd_valid & r_cmd_ready;
  assign w_legal  = is_legal(r_op);
  assign w_ldi    = (r_op == OP_LDI);
  assign w_we     = (r_state == ST_EXEC) && w_legal;
  assign w_wd     = w_ldi ? r_imm : w_alu_result;

  alu_regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .i_ra  (cmd_if.cmd_data[RA_MSB:RA_LSB]),
    .i_rb  (cmd_if.cmd_data[RB_MSB:RB_LSB]),
    .i_we  (w_we),
    .i_wa  (r_rd),
    .i_wd  (w_wd),
    .o_rda (w_rda),
    .o_rdb (w_rdb)
  );

  alu u_alu (
    .i_opcode (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // Control FSM; opcode/operand registers double as the ALU drive and are
  // zero outside EXEC, so the ALU sees LDI/0/0 while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op        <= cmd_if.cmd_data[OP_MSB:OP_LSB];
          r_rd        <= cmd_if.cmd_data[RD_MSB:RD_LSB];
          r_imm       <= cmd_if.cmd_data[IMM_MSB:IMM_LSB];
          r_a         <= w_rda;
          r_b         <= w_rdb;
          r_cmd_ready <= 1'b0;
          r_state     <= ST_EXEC;
        end
        ST_EXEC: begin
          r_op        <= '0;
          r_a         <= '0;
          r_b         <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
          if (!w_legal) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_zero  <= r_zero;
            r_rsp_carry <= r_carry;
          end else if (w_ldi) begin
            r_rsp_data  <= r_imm;
            r_rsp_err   <= 1'b0;
            r_rsp_zero  <= r_zero;
            r_rsp_carry <= r_carry;
          end else begin
            r_rsp_data  <= w_alu_result;
            r_rsp_err   <= 1'b0;
            r_zero      <= (w_alu_result == '0);
            r_carry     <= w_alu_carry;
            r_rsp_zero  <= (w_alu_result == '0);
            r_rsp_carry <= w_alu_carry;
          end
        end
        ST_RESP: if (cmd_if.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = r_cmd_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_data  = r_rsp_data;
  assign cmd_if.rsp_zero  = r_rsp_zero;
  assign cmd_if.rsp_carry = r_rsp_carry;
  assign cmd_if.rsp_err   = r_rsp_err;
  assign alu_opcode       = r_op;
  assign alu_a            = r_a;
  assign alu_b            = r_b;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a response scoreboard.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b;

  alu_sequencer_if ifc ();

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_if     (ifc.slave),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic       c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, push its expected response, then pop and compare
  // when rsp_valid appears. hold>0 keeps rsp_ready low for that many cycles
  // while a second command waits on cmd_valid.
  task automatic issue(input logic [15:0] cmd, input logic [7:0] d,
                       input logic z, input logic c, input logic e, input int hold);
    exp_t ex;
    int   n;
    sb.push_back('{d: d, z: z, c: c, e: e});
    @(negedge clk);
    ifc.rsp_ready = (hold == 0);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = cmd;
    n = 0;
    while (!ifc.cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 10), 32'(1));
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = 16'($urandom);
    @(negedge clk);
    chk("exec_opcode", 32'(alu_opcode), 32'(cmd[15:12]));
    chk("exec_no_rsp", 32'(ifc.rsp_valid), 32'(0));
    n = 0;
    do begin @(negedge clk); n++; end while (!ifc.rsp_valid && n < 10);
    chk("rsp_latency", 32'(n), 32'(1));
    ex = sb.pop_front();
    chk("rsp_data",  32'(ifc.rsp_data),  32'(ex.d));
    chk("rsp_zero",  32'(ifc.rsp_zero),  32'(ex.z));
    chk("rsp_carry", 32'(ifc.rsp_carry), 32'(ex.c));
    chk("rsp_err",   32'(ifc.rsp_err),   32'(ex.e));
    chk("alu_idle",  32'({alu_opcode, alu_a, alu_b}), 32'(0));
    if (hold > 0) begin
      ifc.cmd_valid = 1'b1;
      ifc.cmd_data  = 16'h0455;  // LDI r1=0x55, must never be taken
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(ifc.rsp_valid), 32'(1));
        chk("hold_data",  32'(ifc.rsp_data),  32'(ex.d));
        chk("hold_ready", 32'(ifc.cmd_ready), 32'(0));
      end
      ifc.cmd_valid = 1'b0;
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_hold_ready", 32'(ifc.cmd_ready), 32'(1));
      chk("post_hold_valid", 32'(ifc.rsp_valid), 32'(0));
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = '0;
    ifc.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'(1));
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'(0));
    chk("rst_rsp", 32'({ifc.rsp_data, ifc.rsp_zero, ifc.rsp_carry, ifc.rsp_err}), 32'(0));
    chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'(0));
    reset = 1'b0;

    // Add with carry out and zero result
    issue(16'h04FF, 8'hFF, 1'b0, 1'b0, 1'b0, 0);  // LDI r1,FF
    issue(16'h0801, 8'h01, 1'b0, 1'b0, 1'b0, 0);  // LDI r2,01
    issue(16'h1D80, 8'h00, 1'b1, 1'b1, 1'b0, 0);  // ADD r3,r1,r2
    issue(16'h53C0, 8'h00, 1'b1, 1'b0, 1'b0, 0);  // OR r0,r3,r3 -> r3 is 0
    // Subtract with borrow
    issue(16'h2240, 8'h02, 1'b0, 1'b1, 1'b0, 0);  // SUB r0,r2,r1
    // Shifts / logic / unary ops on 0x81
    issue(16'h0481, 8'h81, 1'b0, 1'b1, 1'b0, 0);  // LDI r1,81 (flags kept)
    issue(16'h9900, 8'h02, 1'b0, 1'b1, 1'b0, 0);  // SHL r2,r1
    issue(16'h8D00, 8'h40, 1'b0, 1'b0, 1'b0, 0);  // SHR r3,r1
    issue(16'h7140, 8'h00, 1'b1, 1'b0, 1'b0, 0);  // XOR r0,r1,r1
    issue(16'h3300, 8'h41, 1'b0, 1'b0, 1'b0, 0);  // INC r0,r3
    issue(16'h61C0, 8'h00, 1'b1, 1'b0, 1'b0, 0);  // AND r0,r1,r3
    issue(16'hA100, 8'h7E, 1'b0, 1'b0, 1'b0, 0);  // ONESCOMP r0,r1
    issue(16'hB100, 8'h7F, 1'b0, 1'b1, 1'b0, 0);  // TWOSCOMP r0,r1
    // Illegal opcode: no write, flags kept
    issue(16'hD400, 8'h00, 1'b0, 1'b1, 1'b1, 0);  // 0xD rd=r1
    issue(16'h0810, 8'h10, 1'b0, 1'b1, 1'b0, 0);  // LDI r2,10 shows flags kept
    issue(16'h5140, 8'h81, 1'b0, 1'b0, 1'b0, 0);  // OR r0,r1,r1 -> r1 still 81
    // Back-pressure on the response channel
    issue(16'h0CA5, 8'hA5, 1'b0, 1'b0, 1'b0, 5);  // LDI r3,A5 held 5 cycles
    issue(16'h5140, 8'h81, 1'b0, 1'b0, 1'b0, 0);  // pending LDI r1,55 was dropped
    // Reset during EXEC
    issue(16'h04FF, 8'hFF, 1'b0, 1'b0, 1'b0, 0);  // LDI r1,FF
    issue(16'h0801, 8'h01, 1'b0, 1'b0, 1'b0, 0);  // LDI r2,01
    issue(16'h1180, 8'h00, 1'b1, 1'b1, 1'b0, 0);  // ADD r0,r1,r2 sets Z,C
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = 16'h1D80;                      // ADD r3,r1,r2
    n = 0;
    while (!ifc.cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("rst_accept_timeout", 32'(n < 10), 32'(1));
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(ifc.rsp_valid), 32'(0));
    chk("abort_cmd_ready", 32'(ifc.cmd_ready), 32'(1));
    chk("abort_alu",       32'({alu_opcode, alu_a, alu_b}), 32'(0));
    issue(16'h0005, 8'h05, 1'b0, 1'b0, 1'b0, 0);  // LDI r0,05: flags cleared
    issue(16'h5180, 8'h00, 1'b1, 1'b0, 1'b0, 0);  // OR r0,r1,r2: r1,r2 cleared
    issue(16'h53C0, 8'h00, 1'b1, 1'b0, 1'b0, 0);  // OR r0,r3,r3: r3 not written
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-side controller that drives the 8-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a local 4x8 register file. It presents opcode and operands to the ALU, captures the ALU result and carry, writes the result back, and returns it with flags over a valid/ready response channel. It sits between the command source (testbench or host FSM) and the combinational ALU.

Parameters:
DATA_W, 8, datapath width; only 8 is supported.
NUM_REGS, 4, register file depth; fixed by the 2-bit register fields.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  instruction word valid
cmd_ready  out  1  sequencer can accept an instruction
cmd_data  in  16  [15:12] opcode, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm (LDI only)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  8  result value
rsp_zero  out  1  Z flag after this instruction
rsp_carry  out  1  C flag after this instruction
rsp_err  out  1  illegal opcode
alu_opcode  out  4  opcode to ALU
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_result  in  8  ALU result
alu_carry_in  in  1  ALU carry out

Behaviour:
- Reset is synchronous, active-high, single clock. Reset values: state IDLE; cmd_ready 1; all other outputs 0; register file 0; Z and C 0.
- Opcodes: 0x0 LDI, rd <= imm. 0x1-0xB are ALU ops (ADD, SUB, INC, DEC, OR, AND, XOR, SHR, SHL, ONESCOMP, TWOSCOMP). 0xC-0xF are illegal.
- State IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the opcode, rd, and imm; latch R[ra] and R[rb] into operand registers; go to EXEC. Any other command remains unaccepted.
- State EXEC (1 cycle): cmd_ready=0. alu_opcode, alu_a and alu_b are driven from registered values, so they are stable the whole cycle. At the end of the cycle:
  - ALU op: capture alu_result and alu_carry_in. Write R[rd] <= result. Z <= (result==0). C <= alu_carry_in.
  - LDI: R[rd] <= imm. Z and C are unchanged.
  - Illegal: no register write. Flags are unchanged. rsp_data=0, rsp_err=1.
  - Then go to RESP.
- State RESP: rsp_valid=1. rsp_data, rsp_zero, rsp_carry and rsp_err stay stable until rsp_valid&rsp_ready. On handshake, go to IDLE.
- Latency: rsp_valid rises 2 cycles after command acceptance. Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- alu_opcode/alu_a/alu_b are 0 outside EXEC. The ALU output is sampled only at the end of EXEC; its default-case X must never propagate.
- Read-after-write: writeback completes before the next acceptance, so the next instruction always reads the updated value. rd may equal ra or rb.
- Z is computed locally from the captured result. The ALU zero output is not used.
- Reset in any state aborts the instruction: no writeback, rsp_valid=0 on the next cycle, register file cleared.
- cmd_data is sampled only on the accepting edge; changes while the sequencer is busy are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants 0x0-0xB as a 4-bit typedef,
  - the state enum (IDLE, EXEC, RESP),
  - instruction field bit positions,
  - DATA_W.
- The ALU module must import the same opcode constants.
- Sub-module alu_regfile: 4x8 registers, two combinational read ports, one synchronous write port, synchronous reset to 0.
- The sequencer instantiates alu_regfile and the ALU.

Test Plan:
1. LDI r1=0xFF; LDI r2=0x01; ADD r3,r1,r2 -> rsp_data=0x00, rsp_zero=1, rsp_carry=1; register r3 holds 0x00.
2. With r1=0xFF, r2=0x01: SUB r0,r2,r1 -> rsp_data=0x02, rsp_carry=1 (borrow), rsp_zero=0.
3. LDI r1=0x81; SHL r2,r1 -> 0x02, carry=1; SHR r3,r1 -> 0x40, carry=0; XOR r0,r1,r1 -> 0x00, zero=1, carry=0.
4. Opcode 0xD with rd=r1 -> rsp_err=1, rsp_data=0x00; r1 and the flags are unchanged.
5. Hold rsp_ready=0 for 5 cycles during a response:
   - rsp_valid and rsp_data stay stable; cmd_ready=0; a pending cmd_valid is not accepted.
   - After rsp_ready rises, cmd_ready=1 on the next cycle.
6. Assert reset during EXEC of ADD r3 -> no write to r3; rsp_valid=0 the next cycle; all registers and flags read 0 afterward.
